// File: rtl/alu_sched.sv
// Two-port request scheduler for a shared, registered ALU: arbitrates, issues, waits
// WAIT_CYC cycles, then holds the captured response. Define ALU_SCHED_FIXED_PRIO_EN for fixed port-0 priority.
module alu_sched #(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_func,
    input  logic        req0_s,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_func,
    input  logic        req1_s,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_func,
    output logic        alu_s,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYC - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_func_q, alu_func_d;
    logic        alu_s_q, alu_s_d;
    logic        id_q, id_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic [3:0]  rsp_flags_q, rsp_flags_d;
    logic        busy_q, busy_d;
    logic        grant_s;
    logic        idle_s;
    logic        hs_s;

    assign idle_s     = (state_q == ST_IDLE);
    assign req0_ready = idle_s & req0_valid & ~grant_s;
    assign req1_ready = idle_s & req1_valid & grant_s;
    assign hs_s       = idle_s & (req0_valid | req1_valid);

`ifdef ALU_SCHED_FIXED_PRIO_EN
    // Fixed priority: port 0 always wins when it is valid
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid) begin
            grant_s = 1'b0;
        end else begin
            grant_s = req1_valid;
        end
    end
`else
    logic pri_q, pri_d;

    // Round-robin winner selection; pri_q names the port that wins the next contention
    always_comb begin
        grant_s = 1'b0;
        pri_d   = pri_q;
        if (req0_valid && req1_valid) begin
            grant_s = pri_q;
        end else if (req0_valid) begin
            grant_s = 1'b0;
        end else begin
            grant_s = req1_valid;
        end
        if (hs_s) begin
            pri_d = ~grant_s;
        end else begin
            pri_d = pri_q;
        end
    end

    // Pointer register, moves only on an accepted request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pri_q <= 1'b0;
        end else begin
            pri_q <= pri_d;
        end
    end
`endif

    // Next-state and datapath latch logic for the scheduling FSM
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_func_d   = alu_func_q;
        alu_s_d      = alu_s_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        case (state_q)
            ST_IDLE: begin
                if (hs_s) begin
                    state_d    = ST_ISSUE;
                    alu_a_d    = grant_s ? req1_a    : req0_a;
                    alu_b_d    = grant_s ? req1_b    : req0_b;
                    alu_func_d = grant_s ? req1_func : req0_func;
                    alu_s_d    = grant_s ? req1_s    : req0_s;
                    id_d       = grant_s;
                    cnt_d      = WAIT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    // alu_s_q still holds the op's s here, so it doubles as the flag mask
                    state_d      = ST_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = id_q;
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_s_q ? alu_flags : 4'b0000;
                    alu_s_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
                alu_s_d     = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            alu_a_q      <= 32'd0;
            alu_b_q      <= 32'd0;
            alu_func_q   <= 3'd0;
            alu_s_q      <= 1'b0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_flags_q  <= 4'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_func_q   <= alu_func_d;
            alu_s_q      <= alu_s_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_func   = alu_func_q;
    assign alu_s      = alu_s_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_sched.sv
// Randomized self-checking bench for alu_sched: a transaction-level model predicts
// arbitration, latency and captured results; a second instance covers WAIT_CYC=3.
module tb_alu_sched;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  func;
        logic        s;
    } op_t;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_s, req1_valid, req1_ready, req1_s;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_func, req1_func;
    logic [31:0] alu_a, alu_b, alu_result, rsp_result;
    logic [2:0]  alu_func;
    logic        alu_s, rsp_valid, rsp_ready, rsp_id, busy;
    logic [3:0]  alu_flags, rsp_flags;

    logic        t_req0_valid, t_req0_ready, t_req1_ready;
    logic [31:0] t_alu_a, t_alu_b, t_alu_result, t_rsp_result;
    logic [2:0]  t_alu_func;
    logic        t_alu_s, t_rsp_valid, t_rsp_ready, t_rsp_id, t_busy;
    logic [3:0]  t_alu_flags, t_rsp_flags;

    int n_checks = 0;
    int n_errors = 0;
    int last_win = 1;

    always #5 clk = ~clk;

    alu_sched #(.WAIT_CYC(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_func(req0_func), .req0_s(req0_s),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_func(req1_func), .req1_s(req1_s),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_s(alu_s),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
    );

    alu_sched #(.WAIT_CYC(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(t_req0_valid), .req0_ready(t_req0_ready), .req0_a(32'd6), .req0_b(32'd7),
        .req0_func(3'b110), .req0_s(1'b0),
        .req1_valid(1'b0), .req1_ready(t_req1_ready), .req1_a(32'd0), .req1_b(32'd0),
        .req1_func(3'b000), .req1_s(1'b0),
        .alu_a(t_alu_a), .alu_b(t_alu_b), .alu_func(t_alu_func), .alu_s(t_alu_s),
        .alu_result(t_alu_result), .alu_flags(t_alu_flags),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_id(t_rsp_id),
        .rsp_result(t_rsp_result), .rsp_flags(t_rsp_flags), .busy(t_busy)
    );

    // Reference ALU: returns {N,Z,C,V, result}; C is carry for ADD and borrow for SUB/CMP
    function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] f);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, v;
        w = 33'd0; r = 32'd0; c = 1'b0; v = 1'b0;
        case (f)
            3'b000: r = a & b;
            3'b001: r = a ^ b;
            3'b010, 3'b100: begin
                r = a - b;
                c = (a < b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'b011: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b101: r = a | b;
            3'b110: r = a * b;
            default: r = 32'd0;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    always_ff @(posedge clk) begin
        {alu_flags, alu_result}     <= alu_model(alu_a, alu_b, alu_func);
        {t_alu_flags, t_alu_result} <= alu_model(t_alu_a, t_alu_b, t_alu_func);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic op_t rand_op();
        op_t o;
        o.a    = $urandom();
        o.b    = ($urandom_range(0, 3) == 0) ? o.a : $urandom();
        o.func = 3'($urandom_range(0, 6));
        o.s    = 1'($urandom_range(0, 1));
        return o;
    endfunction

    function automatic op_t mk_op(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] f, input logic s);
        op_t o;
        o.a = a; o.b = b; o.func = f; o.s = s;
        return o;
    endfunction

    // Expected winner: the port not granted last under contention, else the single valid port
    function automatic int exp_grant(input bit v0, input bit v1);
        if (v0 && v1) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
            return 0;
`else
            return 1 - last_win;
`endif
        end
        return v1 ? 1 : 0;
    endfunction

    task automatic run_op(input bit v0, input bit v1, input op_t o0, input op_t o1,
                          input int hold, output int win);
        op_t         eo;
        logic [35:0] ex;
        logic [3:0]  ef;
        int          g, lat;
        bit          done;
        @(negedge clk);
        req0_valid = v0; req0_a = o0.a; req0_b = o0.b; req0_func = o0.func; req0_s = o0.s;
        req1_valid = v1; req1_a = o1.a; req1_b = o1.b; req1_func = o1.func; req1_s = o1.s;
        rsp_ready = 1'b0;
        #1;
        g = exp_grant(v0, v1);
        check("ready0", req0_ready, (v0 && g == 0));
        check("ready1", req1_ready, (v1 && g == 1));
        win = g;
        last_win = g;
        eo = (g == 1) ? o1 : o0;
        ex = alu_model(eo.a, eo.b, eo.func);
        ef = eo.s ? ex[35:32] : 4'b0000;
        lat = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                check("busy_run", busy, 1);
                check("ready_busy", {req0_ready, req1_ready}, 0);
                check("alu_a", alu_a, eo.a);
                check("alu_b", alu_b, eo.b);
                check("alu_func", alu_func, eo.func);
                check("alu_s", alu_s, eo.s);
            end
        end
        check("rsp_timeout", done, 1);
        check("latency", lat, 2 + W);
        for (int k = 0; k <= hold; k++) begin
            if (k > 0) @(negedge clk);
            check("rsp_valid", rsp_valid, 1);
            check("rsp_id", rsp_id, g);
            check("rsp_result", rsp_result, ex[31:0]);
            check("rsp_flags", rsp_flags, ef);
            check("alu_s_resp", alu_s, 0);
            check("ready_resp", {req0_ready, req1_ready}, 0);
        end
        rsp_ready = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("rsp_drop", rsp_valid, 0);
        check("busy_idle", busy, 0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        op_t ops0[4];
        op_t ops1[4];
        op_t none;
        int  w, i0, i1, lat;
        bit  done;
        none = mk_op(32'd0, 32'd0, 3'd0, 1'b0);
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_func = 3'd0; req0_s = 1'b0;
        req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_func = 3'd0; req1_s = 1'b0;
        rsp_ready = 1'b0; t_req0_valid = 1'b0; t_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_alu", {alu_a, alu_func, alu_s}, 0);
        rst = 1'b0;

        run_op(1'b1, 1'b0, mk_op(32'd5, 32'd7, 3'b011, 1'b1), none, 0, w);
        run_op(1'b0, 1'b1, none, mk_op(32'd3, 32'd3, 3'b010, 1'b1), 0, w);
        run_op(1'b0, 1'b1, none, mk_op(32'd3, 32'd3, 3'b010, 1'b0), 0, w);

        for (int k = 0; k < 4; k++) begin
            ops0[k] = rand_op();
            ops1[k] = rand_op();
        end
        i0 = 0; i1 = 0;
        while (i0 < 4 || i1 < 4) begin
            run_op(i0 < 4, i1 < 4, ops0[i0 & 3], ops1[i1 & 3], 0, w);
            if (w == 0) i0++; else i1++;
        end

        run_op(1'b1, 1'b0, rand_op(), none, 5, w);

        // Abort an op in WAIT, first leaving the pointer favouring port 1
        run_op(1'b1, 1'b0, rand_op(), none, 0, w);
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd4; req0_func = 3'b011; req0_s = 1'b1;
        #1;
        check("ready_pre_rst", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        check("busy_pre_rst", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_valid", rsp_valid, 0);
        check("rst_mid_alu_s", alu_s, 0);
        @(negedge clk);
        rst = 1'b0;
        last_win = 1;
        repeat (4) begin
            @(negedge clk);
            check("no_rsp_after_rst", rsp_valid, 0);
        end
        run_op(1'b1, 1'b1, rand_op(), rand_op(), 0, w);

        for (int n = 0; n < 40; n++) begin
            int p;
            p = $urandom_range(1, 3);
            run_op(p[0], p[1], rand_op(), rand_op(), $urandom_range(0, 3), w);
        end

        @(negedge clk);
        t_req0_valid = 1'b1;
        t_rsp_ready = 1'b1;
        #1;
        check("w3_ready", t_req0_ready, 1);
        lat = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            t_req0_valid = 1'b0;
            lat++;
            if (t_rsp_valid) done = 1'b1;
        end
        check("w3_timeout", done, 1);
        check("w3_latency", lat, 5);
        check("w3_result", t_rsp_result, 32'd42);
        check("w3_id_flags", {t_rsp_id, t_rsp_flags}, 0);
        @(negedge clk);
        check("w3_done", {t_rsp_valid, t_busy}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
